// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//
// This module is the refill controller for the L1 instruction cache. A fetch
// miss latches the line-aligned address. It then requests a burst from the
// next memory level and writes each returning beat into the data array. After
// the last beat it pulses a tag/valid commit.
//
// A control-flow redirect can arrive while a fill is in flight. In that case
// the burst already promised by memory is drained in ABORT, with no writes and
// no commit, so the cache is never left half-updated.
//
// Ports
//   clk_i, reset_i       clock, asynchronous active-high reset
//   pc_f_i               fetch PC
//   fetch_en_i           fetch stage presents a lookup this cycle
//   lookup_hit_i         tag-compare result for pc_f_i
//   redirect_i           taken-branch / mispredict redirect
//   mem_req_o            burst request, held until mem_gnt_i
//   mem_addr_o           line-aligned burst base address
//   mem_gnt_i            burst accepted; BLOCK_WORDS beats follow
//   mem_rvalid_i         read beat valid (word order 0..N-1)
//   mem_rdata_i          read beat data
//   fill_we_o            data-array word write enable
//   fill_word_o          word index of the current write
//   fill_data_o          write data (mem_rdata_i)
//   fill_line_addr_o     line address being filled
//   fill_commit_o        one-cycle tag write / valid set
//   instr_hit_f_o        fetched instruction valid (low stalls)
//   ic_repl_permit_o     a redirect may flush without corrupting a fill
//   miss_count_o         saturating count of misses that started a fill
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [ADDR_WIDTH-1:0]          pc_f_i,
  input  logic                           fetch_en_i,
  input  logic                           lookup_hit_i,
  input  logic                           redirect_i,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           fill_we_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_o,
  output logic [31:0]                    fill_data_o,
  output logic [ADDR_WIDTH-1:0]          fill_line_addr_o,
  output logic                           fill_commit_o,
  output logic                           instr_hit_f_o,
  output logic                           ic_repl_permit_o,
  output logic [31:0]                    miss_count_o
);

  localparam int WI  = $clog2(BLOCK_WORDS);
  localparam int OFF = WI + 2;  // byte-offset bits within a line

  localparam logic [WI:0]   BEATS_FULL = (WI+1)'(BLOCK_WORDS);
  localparam logic [WI-1:0] LAST_IDX   = WI'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_COMMIT,
    S_ABORT
  } state_e;

  state_e                  state_q, state_d;
  logic [WI-1:0]           cnt_q, cnt_d;     // next beat index in FILL
  logic [WI:0]             rem_q, rem_d;     // beats still to drain in ABORT
  logic [ADDR_WIDTH-1:0]   line_q, line_d;
  logic [31:0]             miss_q, miss_d;
  logic                    req_q, commit_q;

  // The word/byte offset bits of the PC never reach the line address.
  logic unused_pc_offset;
  assign unused_pc_offset = ^pc_f_i[OFF-1:0];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      line_q   <= '0;
      miss_q   <= '0;
      req_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      line_q   <= line_d;
      miss_q   <= miss_d;
      // Registered so both are high exactly while in their state.
      req_q    <= (state_d == S_REQ);
      commit_q <= (state_d == S_COMMIT);
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rem_d            = rem_q;
    line_d           = line_q;
    miss_d           = miss_q;
    fill_we_o        = 1'b0;
    instr_hit_f_o    = 1'b0;
    ic_repl_permit_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gated so a held reset never reports a hit.
        instr_hit_f_o    = lookup_hit_i & ~reset_i;
        ic_repl_permit_o = 1'b1;
        if (fetch_en_i && !lookup_hit_i && !redirect_i) begin
          line_d  = {pc_f_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          miss_d  = sat_inc(miss_q);
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_gnt_i && !redirect_i) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end else if (redirect_i && !mem_gnt_i) begin
          state_d = S_IDLE;
        end else if (redirect_i && mem_gnt_i) begin
          // The burst is already committed by memory; drain all of it.
          rem_d   = BEATS_FULL;
          state_d = S_ABORT;
        end
      end

      S_FILL: begin
        if (mem_rvalid_i) begin
          fill_we_o = 1'b1;
          cnt_d     = cnt_q + WI'(1);
        end
        // The last beat completes the line even under a simultaneous redirect.
        if (mem_rvalid_i && cnt_q == LAST_IDX) begin
          state_d = S_COMMIT;
        end else if (redirect_i) begin
          rem_d   = BEATS_FULL - ({1'b0, cnt_q} + (WI+1)'(mem_rvalid_i));
          state_d = S_ABORT;
        end
      end

      S_COMMIT: begin
        ic_repl_permit_o = 1'b1;
        state_d          = S_IDLE;
      end

      S_ABORT: begin
        if (mem_rvalid_i) begin
          if (rem_q == (WI+1)'(1)) begin
            state_d = S_IDLE;
          end else begin
            rem_d = rem_q - (WI+1)'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_o        = req_q;
  assign mem_addr_o       = line_q;
  assign fill_word_o      = cnt_q;
  assign fill_data_o      = mem_rdata_i;
  assign fill_line_addr_o = line_q;
  assign fill_commit_o    = commit_q;
  assign miss_count_o     = miss_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_ctrl
//
// Randomized bench for icache_fill_ctrl. Each miss episode is described by a
// grant delay, a beat-gap setting and a redirect scenario. The reference model
// tracks only transaction-level facts: whether the line is still being
// written, how many beats memory has delivered, the expected miss count, and
// whether a commit is owed. Every cycle's outputs are compared against those
// facts.
// ---------------------------------------------------------------------------
module tb_icache_fill_ctrl;

  localparam int BW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_f;
  logic          fetch_en, lookup_hit, redirect;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt, mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          fill_we;
  logic [1:0]    fill_word;
  logic [31:0]   fill_data;
  logic [AW-1:0] fill_line_addr;
  logic          fill_commit, instr_hit_f, ic_repl_permit;
  logic [31:0]   miss_count;

  int checks = 0;
  int errors = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  icache_fill_ctrl #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .pc_f_i           (pc_f),
    .fetch_en_i       (fetch_en),
    .lookup_hit_i     (lookup_hit),
    .redirect_i       (redirect),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_gnt_i        (mem_gnt),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata),
    .fill_we_o        (fill_we),
    .fill_word_o      (fill_word),
    .fill_data_o      (fill_data),
    .fill_line_addr_o (fill_line_addr),
    .fill_commit_o    (fill_commit),
    .instr_hit_f_o    (instr_hit_f),
    .ic_repl_permit_o (ic_repl_permit),
    .miss_count_o     (miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 after the rising edge; outputs are sampled 1 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_misc();
    fetch_en   = 1'($urandom);
    lookup_hit = 1'($urandom);
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
    pc_f       = $urandom;
  endtask

  // An IDLE cycle that must not start a fill.
  task automatic idle_cycle();
    next_cycle();
    randomize_misc();
    redirect = 1'($urandom);
    if (fetch_en && !lookup_hit) redirect = 1'b1;
    #1;
    check("idle_hit",    32'(instr_hit_f),    32'(lookup_hit));
    check("idle_permit", 32'(ic_repl_permit), 32'd1);
    check("idle_req",    32'(mem_req),        32'd0);
    check("idle_we",     32'(fill_we),        32'd0);
    check("idle_misses", miss_count,          32'(exp_miss));
  endtask

  // mode: 0 clean fill, 1 redirect in REQ before grant, 2 redirect with grant,
  //       3 redirect on beat number k (1..BW-1), 4 redirect in a no-beat FILL
  //       cycle after k beats (0..BW-1), 5 redirect on the last beat.
  task automatic run_miss(input int gnt_delay, input int mode, input int k, input bit gaps);
    logic [AW-1:0] line;
    bit in_fill, commit_exp;
    int sent, cyc;
    logic rv, hit_now;

    // Miss cycle.
    next_cycle();
    randomize_misc();
    fetch_en = 1'b1; lookup_hit = 1'b0; redirect = 1'b0;
    line = pc_f & ~AW'(BW * 4 - 1);
    #1;
    check("miss_hit",    32'(instr_hit_f),    32'd0);
    check("miss_permit", 32'(ic_repl_permit), 32'd1);
    check("miss_req",    32'(mem_req),        32'd0);
    check("miss_cnt0",   miss_count,          32'(exp_miss));
    if (exp_miss != 32'hFFFF_FFFF) exp_miss++;

    // Request phase.
    for (int d = 0; d <= gnt_delay; d++) begin
      next_cycle();
      randomize_misc();
      mem_gnt  = (d == gnt_delay);
      redirect = 1'b0;
      if (mode == 1 && d == gnt_delay) begin mem_gnt = 1'b0; redirect = 1'b1; end
      if (mode == 2 && d == gnt_delay) redirect = 1'b1;
      #1;
      check("req_req",    32'(mem_req),        32'd1);
      check("req_addr",   mem_addr,            line);
      check("req_permit", 32'(ic_repl_permit), 32'd0);
      check("req_hit",    32'(instr_hit_f),    32'd0);
      check("req_we",     32'(fill_we),        32'd0);
      check("req_misses", miss_count,          32'(exp_miss));
    end

    if (mode == 1) begin
      next_cycle();
      randomize_misc();
      fetch_en = 1'b0; redirect = 1'b0;
      #1;
      check("rq_abort_req",    32'(mem_req),        32'd0);
      check("rq_abort_permit", 32'(ic_repl_permit), 32'd1);
      check("rq_abort_hit",    32'(instr_hit_f),    32'(lookup_hit));
      check("rq_abort_commit", 32'(fill_commit),    32'd0);
      return;
    end

    // Burst phase: memory always delivers all BW beats.
    in_fill = (mode != 2);
    commit_exp = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < BW && cyc < 200) begin
      next_cycle();
      cyc++;
      randomize_misc();
      rv = gaps ? 1'($urandom) : 1'b1;
      redirect = in_fill ? 1'b0 : 1'($urandom);
      if (in_fill && mode == 3 && sent == k - 1) begin rv = 1'b1; redirect = 1'b1; end
      if (in_fill && mode == 4 && sent == k)     begin rv = 1'b0; redirect = 1'b1; end
      if (in_fill && mode == 5 && sent == BW - 1) begin rv = 1'b1; redirect = 1'b1; end
      mem_rvalid = rv;
      #1;
      check("beat_we", 32'(fill_we), 32'(in_fill && rv));
      if (in_fill && rv) begin
        check("beat_word", 32'(fill_word), 32'(sent));
        check("beat_data", fill_data,      mem_rdata);
      end
      check("beat_permit", 32'(ic_repl_permit), 32'd0);
      check("beat_hit",    32'(instr_hit_f),    32'd0);
      check("beat_req",    32'(mem_req),        32'd0);
      check("beat_commit", 32'(fill_commit),    32'd0);
      if (rv) sent++;
      if (in_fill) begin
        if (rv && sent == BW) commit_exp = 1'b1;
        else if (redirect)    in_fill = 1'b0;
      end
    end
    if (cyc >= 200) check("burst_timeout", 32'(cyc), 32'd0);

    // Commit or straight back to IDLE.
    next_cycle();
    randomize_misc();
    fetch_en = 1'b0;
    redirect = 1'($urandom);
    hit_now = lookup_hit;
    #1;
    check("post_commit", 32'(fill_commit),    32'(commit_exp));
    check("post_permit", 32'(ic_repl_permit), 32'd1);
    check("post_we",     32'(fill_we),        32'd0);
    check("post_hit",    32'(instr_hit_f),    commit_exp ? 32'd0 : 32'(hit_now));
    if (commit_exp) begin
      check("commit_line", fill_line_addr, line);
      next_cycle();
      randomize_misc();
      fetch_en = 1'b0;
      redirect = 1'($urandom);
      #1;
      check("after_commit",     32'(fill_commit),    32'd0);
      check("after_commit_hit", 32'(instr_hit_f),    32'(lookup_hit));
      check("after_commit_prm", 32'(ic_repl_permit), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(mem_req),        32'd0);
    check({tag, "_we"},     32'(fill_we),        32'd0);
    check({tag, "_commit"}, 32'(fill_commit),    32'd0);
    check({tag, "_hit"},    32'(instr_hit_f),    32'd0);
    check({tag, "_permit"}, 32'(ic_repl_permit), 32'd1);
    check({tag, "_misses"}, miss_count,          32'd0);
    check({tag, "_addr"},   mem_addr,            32'd0);
    check({tag, "_line"},   fill_line_addr,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pc_f = '0; fetch_en = 1'b0; lookup_hit = 1'b1; redirect = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    next_cycle();
    rst = 1'b0;
    exp_miss = 0;

    // Test-plan scenarios first, then random episodes.
    run_miss(0, 0, 0, 1'b0);
    run_miss(3, 0, 0, 1'b1);
    run_miss(2, 1, 0, 1'b0);
    run_miss(0, 3, 1, 1'b0);
    run_miss(1, 2, 0, 1'b1);
    run_miss(0, 5, 0, 1'b0);
    run_miss(0, 4, 0, 1'b1);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      int m, kk;
      m  = int'($urandom_range(0, 5));
      kk = (m == 3) ? int'($urandom_range(1, BW - 1)) : int'($urandom_range(0, BW - 1));
      run_miss(int'($urandom_range(0, 3)), m, kk, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Asynchronous reset in the middle of a fill.
    next_cycle();
    fetch_en = 1'b1; lookup_hit = 1'b0; redirect = 1'b0; pc_f = 32'h0000_5678;
    next_cycle();
    fetch_en = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("pre_reset_we", 32'(fill_we), 32'd1);
    #2;
    rst = 1'b1;
    lookup_hit = 1'b1;
    #1;
    check_reset_outputs("midfill_reset");
    next_cycle();
    rst = 1'b0;
    exp_miss = 0;
    run_miss(0, 0, 0, 1'b0);
    check("final_misses", miss_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
